serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor, the inverse of the team's full-adder datapath.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 164 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   sub_state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width() : width of the bit counter for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  // Counter runs 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell.
//   a, b : operand bits (computes a - b - bi)
//   bi   : borrow in
//   d    : difference bit
//   bo   : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per
// clock through a single full_subtractor cell with a registered borrow.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start_valid/start_ready  operand handshake (a, b, bin)
//   res_valid/res_ready      result handshake (diff, bout, ovf)
//   diff                     a - b - bin modulo 2^WIDTH
//   bout                     borrow out of the MSB
//   busy                     high while in SHIFT or DONE
//   ovf                      signed overflow, present only when
//                            SERIAL_SUB_OVF_EN is defined
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             res_valid_q, res_valid_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bo;

  full_subtractor u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    bout_d      = bout_q;
    res_valid_d = res_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        diff_d   = {cell_d, diff_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        borrow_d = cell_bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          bout_d      = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
          // cell_d is the final diff MSB on this edge.
          ovf_d       = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      bout_q      <= bout_d;
      res_valid_q <= res_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    res_valid   = res_valid_q;
    diff        = diff_q;
    bout        = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf         = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances).
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       sv8, sr8, rv8, rr8, bin8, bo8, busy8;
  logic [7:0] a8, b8, d8;
  logic       sv2, sr2, rv2, rr2, bin2, bo2, busy2;
  logic [1:0] a2, b2, d2;
`ifdef SERIAL_SUB_OVF_EN
  logic       ov8, ov2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .bin(bin8), .res_valid(rv8), .res_ready(rr8),
    .diff(d8), .bout(bo8), .busy(busy8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ov8)
`endif
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
    .a(a2), .b(b2), .bin(bin2), .res_valid(rv2), .res_ready(rr2),
    .diff(d2), .bout(bo2), .busy(busy2)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ov2)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, bout, diff}.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int r;
    int s;
    logic [7:0] d;
    r = int'(a) - int'(b) - int'(bi);
    s = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d = r[7:0];
    return {(s < -128 || s > 127), (r < 0), d};
  endfunction

  function automatic logic [2:0] model2(input logic [1:0] a, input logic [1:0] b, input logic bi);
    int r;
    logic [1:0] d;
    r = int'(a) - int'(b) - int'(bi);
    d = r[1:0];
    return {(r < 0), d};
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     output logic [7:0] d, output logic bo, output logic ov);
    int lat;
    check("w8_start_ready_idle", sr8, 1);
    a8 = a; b8 = b; bin8 = bi; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    check("w8_busy_after_accept", busy8, 1);
    lat = 0;
    while (!rv8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_latency", lat, 8);
    d  = d8;
    bo = bo8;
`ifdef SERIAL_SUB_OVF_EN
    ov = ov8;
`else
    ov = 1'b0;
`endif
    rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
    check("w8_res_valid_cleared", rv8, 0);
    check("w8_start_ready_back", sr8, 1);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                     output logic [1:0] d, output logic bo);
    int lat;
    a2 = a; b2 = b; bin2 = bi; sv2 = 1'b1;
    @(posedge clk); #1;
    sv2 = 1'b0;
    lat = 0;
    while (!rv2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w2_latency", lat, 2);
    d  = d2;
    bo = bo2;
    rr2 = 1'b1;
    @(posedge clk); #1;
    rr2 = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] dd;
    logic       bo, ov;
    logic [9:0] m;
    logic [2:0] m2;
    logic [7:0] ra, rb;
    logic       rbi;
    int         lat;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    tbl[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    tbl[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};

    rst = 1'b1;
    sv8 = 0; rr8 = 0; a8 = '0; b8 = '0; bin8 = 0;
    sv2 = 0; rr2 = 0; a2 = '0; b2 = '0; bin2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_start_ready", sr8, 1);
    check("reset_res_valid", rv8, 0);
    check("reset_busy", busy8, 0);
    check("reset_diff", d8, 0);
    check("reset_bout", bo8, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", ov8, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].bin, d, bo, ov);
      check($sformatf("tbl%0d_diff", i), d, tbl[i].diff);
      check($sformatf("tbl%0d_bout", i), bo, tbl[i].bout);
    end

`ifdef SERIAL_SUB_OVF_EN
    op8(8'h80, 8'h01, 1'b0, d, bo, ov);
    check("ovf_80_01_diff", d, 8'h7F);
    check("ovf_80_01_ovf", ov, 1);
    op8(8'h7F, 8'h01, 1'b0, d, bo, ov);
    check("ovf_7f_01_diff", d, 8'h7E);
    check("ovf_7f_01_ovf", ov, 0);
`endif

    // Randomized against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      m = model8(ra, rb, rbi);
      op8(ra, rb, rbi, d, bo, ov);
      check($sformatf("rnd%0d_diff", i), d, m[7:0]);
      check($sformatf("rnd%0d_bout", i), bo, m[8]);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("rnd%0d_ovf", i), ov, m[9]);
`endif
    end

    // Back-pressure in DONE: result held, new starts ignored
    a8 = 8'h03; b8 = 8'h05; bin8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    lat = 0;
    while (!rv8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      sv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      check("hold_res_valid", rv8, 1);
      check("hold_diff", d8, 8'hFE);
      check("hold_bout", bo8, 1);
      check("hold_start_ready", sr8, 0);
    end
    sv8 = 1'b0; rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
    check("release_res_valid", rv8, 0);
    check("release_start_ready", sr8, 1);
    check("release_busy", busy8, 0);
    @(posedge clk); #1;
    check("release_stays_idle", busy8, 0);

    // Reset mid-SHIFT at count 3
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", busy8, 1);
    rst = 1'b1;
    #1;
    check("abort_start_ready", sr8, 1);
    check("abort_busy", busy8, 0);
    check("abort_diff", d8, 0);
    check("abort_bout", bo8, 0);
    @(posedge clk); #1;
    check("abort_res_valid", rv8, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    op8(8'h10, 8'h01, 1'b0, d, bo, ov);
    check("post_reset_diff", d, 8'h0F);
    check("post_reset_bout", bo, 0);

    // Exhaustive WIDTH=2
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      m2 = model2(v[1:0], v[3:2], v[4]);
      op2(v[1:0], v[3:2], v[4], dd, bo);
      check($sformatf("w2_%0d_diff", i), dd, m2[1:0]);
      check($sformatf("w2_%0d_bout", i), bo, m2[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
